// File: rtl/fetch_line_buffer_if.sv
// Fetch-side and instruction-bus signals of fetch_line_buffer.
// The slave modport is the buffer; the master modport is the fetch stage plus bus arbiter.
interface fetch_line_buffer_if #(
    parameter int unsigned BUS_DATA_WIDTH = 64,
    parameter int unsigned BUS_TAG_WIDTH  = 13
);
    logic                      pc_valid;
    logic [BUS_DATA_WIDTH-1:0] pc;
    logic                      flush;
    logic                      ins_valid;
    logic [31:0]               ins;
    logic [BUS_DATA_WIDTH-1:0] ins_addr;
    logic                      bus_reqcyc;
    logic [BUS_DATA_WIDTH-1:0] bus_req;
    logic [BUS_TAG_WIDTH-1:0]  bus_reqtag;
    logic                      bus_reqack;
    logic                      bus_respcyc;
    logic [BUS_DATA_WIDTH-1:0] bus_resp;
    logic [BUS_TAG_WIDTH-1:0]  bus_resptag;
    logic                      bus_respack;

    modport slave (
        input  pc, pc_valid, flush, bus_reqack, bus_respcyc, bus_resp, bus_resptag,
        output ins_valid, ins, ins_addr, bus_reqcyc, bus_req, bus_reqtag, bus_respack
    );

    modport master (
        output pc, pc_valid, flush, bus_reqack, bus_respcyc, bus_resp, bus_resptag,
        input  ins_valid, ins, ins_addr, bus_reqcyc, bus_req, bus_reqtag, bus_respack
    );
endinterface

// File: rtl/fetch_line_buffer.sv
// Single-line instruction buffer: serves 32-bit words from one buffered 64-byte line and
// refills the line with one request plus an 8-beat burst on a miss.
module fetch_line_buffer #(
    parameter int unsigned              BUS_DATA_WIDTH = 64,
    parameter int unsigned              BUS_TAG_WIDTH  = 13,
    parameter logic [BUS_TAG_WIDTH-1:0] READ_TAG       = 13'h1100,
    parameter int unsigned              LINE_BEATS     = 8
) (
    input logic                clk,
    input logic                reset,
    fetch_line_buffer_if.slave fb
);
    localparam int unsigned AddrW = BUS_DATA_WIDTH;
    localparam int unsigned OffW  = $clog2(LINE_BEATS * 8);
    localparam int unsigned BeatW = $clog2(LINE_BEATS);

    typedef enum logic [1:0] {StIdle, StReq, StFill} state_e;

    state_e                 state_q, state_d;
    logic [AddrW-1:OffW]    line_tag_q, line_tag_d;
    logic                   line_valid_q, line_valid_d;
    logic [BeatW-1:0]       beat_cnt_q, beat_cnt_d;
    logic                   discard_q, discard_d;
    logic [AddrW-1:0]       req_addr_q, req_addr_d;
    logic                   ins_valid_q, ins_valid_d;
    logic [31:0]            ins_q, ins_d;
    logic [AddrW-1:0]       ins_addr_q, ins_addr_d;
    logic [AddrW-1:0]       data_q [LINE_BEATS];

    logic                   hit;
    logic                   beat_acc;
    logic                   last_beat;
    logic [AddrW-1:0]       hit_line;
    logic                   unused_inputs;

    assign unused_inputs = ^{fb.bus_resptag, fb.pc[1:0]};

    assign hit = (state_q == StIdle) && fb.pc_valid && line_valid_q && !fb.flush &&
                 (line_tag_q == fb.pc[AddrW-1:OffW]);
    assign hit_line  = data_q[fb.pc[OffW-1:3]];
    assign beat_acc  = (state_q == StFill) && fb.bus_respcyc;
    assign last_beat = (beat_cnt_q == BeatW'(LINE_BEATS - 1));

    always_comb begin
        state_d      = state_q;
        line_tag_d   = line_tag_q;
        line_valid_d = line_valid_q;
        beat_cnt_d   = beat_cnt_q;
        discard_d    = discard_q;
        req_addr_d   = req_addr_q;
        ins_valid_d  = 1'b0;
        ins_d        = ins_q;
        ins_addr_d   = ins_addr_q;

        unique case (state_q)
            StIdle: begin
                if (fb.flush) begin
                    line_valid_d = 1'b0;
                end
                if (hit) begin
                    ins_valid_d = 1'b1;
                    ins_d       = fb.pc[2] ? hit_line[63:32] : hit_line[31:0];
                    ins_addr_d  = {fb.pc[AddrW-1:2], 2'b00};
                end else if (fb.pc_valid) begin
                    req_addr_d = {fb.pc[AddrW-1:OffW], {OffW{1'b0}}};
                    state_d    = StReq;
                end
            end
            StReq: begin
                if (fb.flush) begin
                    discard_d = 1'b1;
                end
                if (fb.bus_reqack) begin
                    state_d      = StFill;
                    beat_cnt_d   = '0;
                    line_valid_d = 1'b0;
                end
            end
            StFill: begin
                if (fb.flush) begin
                    discard_d = 1'b1;
                end
                if (beat_acc) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (last_beat) begin
                        // A flush landing on the last beat still keeps the line invalid.
                        state_d      = StIdle;
                        line_tag_d   = req_addr_q[AddrW-1:OffW];
                        line_valid_d = !discard_q && !fb.flush;
                        discard_d    = 1'b0;
                        beat_cnt_d   = '0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            line_tag_q   <= '0;
            line_valid_q <= 1'b0;
            beat_cnt_q   <= '0;
            discard_q    <= 1'b0;
            req_addr_q   <= '0;
            ins_valid_q  <= 1'b0;
            ins_q        <= '0;
            ins_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            line_tag_q   <= line_tag_d;
            line_valid_q <= line_valid_d;
            beat_cnt_q   <= beat_cnt_d;
            discard_q    <= discard_d;
            req_addr_q   <= req_addr_d;
            ins_valid_q  <= ins_valid_d;
            ins_q        <= ins_d;
            ins_addr_q   <= ins_addr_d;
        end
    end

    // Line storage needs no reset: it is only read while line_valid_q is set.
    always_ff @(posedge clk) begin
        if (beat_acc) begin
            data_q[beat_cnt_q] <= fb.bus_resp;
        end
    end

    // Handshakes are masked by reset so no beat is acked in the cycle reset aborts a fill.
    assign fb.bus_reqcyc  = (state_q == StReq) && !reset;
    assign fb.bus_req     = req_addr_q;
    assign fb.bus_reqtag  = (state_q == StReq) ? READ_TAG : '0;
    assign fb.bus_respack = beat_acc && !reset;

    assign fb.ins_valid = ins_valid_q;
    assign fb.ins       = ins_q;
    assign fb.ins_addr  = ins_addr_q;
endmodule

// File: tb/tb_fetch_line_buffer.sv
// Scoreboard bench for fetch_line_buffer: stimulus queues expected words and requests,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_fetch_line_buffer;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    fetch_line_buffer_if #(.BUS_DATA_WIDTH(64), .BUS_TAG_WIDTH(13)) fb ();

    fetch_line_buffer #(
        .BUS_DATA_WIDTH(64),
        .BUS_TAG_WIDTH (13),
        .READ_TAG      (13'h1100),
        .LINE_BEATS    (8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .fb   (fb)
    );

    typedef struct {
        logic [31:0] ins;
        logic [63:0] addr;
        int          cyc;
    } ins_exp_t;

    ins_exp_t    exp_ins[$];
    logic [63:0] exp_req[$];
    ins_exp_t    mon_e;
    logic [63:0] mon_r;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          beats_acked = 0;
    int          b0;

    logic        prev_reqcyc = 1'b0;
    logic        prev_reqack = 1'b0;
    logic [63:0] prev_req = '0;
    logic [12:0] prev_tag = '0;

    function automatic void check64(input string name, input logic [63:0] act,
                                    input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset) begin
            if (fb.ins_valid) begin
                if (exp_ins.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ins: got ins %h addr %h expected no output",
                             fb.ins, fb.ins_addr);
                end else begin
                    mon_e = exp_ins.pop_front();
                    check64("ins", {32'h0, fb.ins}, {32'h0, mon_e.ins});
                    check64("ins_addr", fb.ins_addr, mon_e.addr);
                    if (mon_e.cyc >= 0) check64("ins_latency", 64'(cyc), 64'(mon_e.cyc));
                end
            end
            if (fb.bus_reqcyc && prev_reqcyc && !prev_reqack) begin
                check64("req_stable", fb.bus_req, prev_req);
                check64("reqtag_stable", {51'h0, fb.bus_reqtag}, {51'h0, prev_tag});
            end
            if (fb.bus_reqcyc && fb.bus_reqack) begin
                if (exp_req.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_req: got addr %h expected no request", fb.bus_req);
                end else begin
                    mon_r = exp_req.pop_front();
                    check64("req_addr", fb.bus_req, mon_r);
                    check64("req_tag", {51'h0, fb.bus_reqtag}, 64'h1100);
                end
            end
            if (fb.bus_respack) beats_acked++;
        end
        prev_reqcyc = fb.bus_reqcyc;
        prev_reqack = fb.bus_reqack;
        prev_req    = fb.bus_req;
        prev_tag    = fb.bus_reqtag;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (!fb.bus_reqcyc && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (!fb.bus_reqcyc) begin
            errors++;
            $display("FAIL %s: got reqcyc 0 after 20 cycles expected 1", name);
        end
    endtask

    task automatic ack(input int delay);
        wait_req("req_issued");
        repeat (delay) step();
        fb.bus_reqack = 1'b1;
        step();
        fb.bus_reqack = 1'b0;
    endtask

    // Beat i of line base carries {0x11110000+off, 0x22220000+off+i}, off = base-0x1000.
    task automatic feed(input logic [63:0] base, input bit gaps, input int flush_at,
                        input int nbeats);
        logic [31:0] off;
        off = base[31:0] - 32'h1000;
        for (int i = 0; i < nbeats; i++) begin
            if (gaps) begin
                fb.bus_respcyc = 1'b0;
                fb.bus_resp    = 64'hdead_beef_dead_beef;
                #1;
                check64("respack_gap", {63'h0, fb.bus_respack}, 64'h0);
                step();
            end
            fb.bus_respcyc = 1'b1;
            fb.bus_resp    = {32'h1111_0000 + off, 32'h2222_0000 + off + 32'(i)};
            fb.flush       = (i == flush_at);
            #1;
            check64("respack_beat", {63'h0, fb.bus_respack}, 64'h1);
            step();
        end
        fb.bus_respcyc = 1'b0;
        fb.flush       = 1'b0;
    endtask

    task automatic fill(input logic [63:0] a, input int delay, input bit gaps,
                        input int flush_at);
        fb.pc       = a;
        fb.pc_valid = 1'b1;
        exp_req.push_back({a[63:6], 6'b0});
        step();
        ack(delay);
        feed({a[63:6], 6'b0}, gaps, flush_at, 8);
        step();
        fb.pc_valid = 1'b0;
    endtask

    task automatic hit(input logic [63:0] a, input logic [31:0] w);
        fb.pc       = a;
        fb.pc_valid = 1'b1;
        exp_ins.push_back(ins_exp_t'{w, {a[63:2], 2'b00}, cyc + 1});
        step();
        fb.pc_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000 expected finish");
        $fatal(1);
    end

    initial begin
        reset          = 1'b1;
        fb.pc          = '0;
        fb.pc_valid    = 1'b0;
        fb.flush       = 1'b0;
        fb.bus_reqack  = 1'b0;
        fb.bus_respcyc = 1'b1;
        fb.bus_resp    = '0;
        fb.bus_resptag = '0;
        step();
        step();
        check64("rst_ins_valid", {63'h0, fb.ins_valid}, 64'h0);
        check64("rst_ins", {32'h0, fb.ins}, 64'h0);
        check64("rst_ins_addr", fb.ins_addr, 64'h0);
        check64("rst_reqcyc", {63'h0, fb.bus_reqcyc}, 64'h0);
        check64("rst_req", fb.bus_req, 64'h0);
        check64("rst_reqtag", {51'h0, fb.bus_reqtag}, 64'h0);
        check64("rst_respack", {63'h0, fb.bus_respack}, 64'h0);
        reset          = 1'b0;
        fb.bus_respcyc = 1'b0;
        step();

        // Cold miss with the minimum 11-cycle latency.
        exp_ins.push_back(ins_exp_t'{32'h1111_0000, 64'h1004, cyc + 11});
        fill(64'h1004, 0, 1'b0, -1);
        hit(64'h1038, 32'h2222_0007);
        hit(64'h1000, 32'h2222_0000);
        step();
        check64("hit_no_req", {63'h0, fb.bus_reqcyc}, 64'h0);

        // Late ack and gapped beats.
        exp_ins.push_back(ins_exp_t'{32'h2222_1005, 64'h2028, -1});
        b0 = beats_acked;
        fill(64'h2028, 3, 1'b1, -1);
        check64("beats_acked", 64'(beats_acked - b0), 64'd8);
        hit(64'h201c, 32'h1111_1000);

        // Flush on beat 4 leaves the line invalid, so the same pc refetches it.
        exp_req.push_back(64'h3000);
        fill(64'h3000, 0, 1'b0, 4);
        exp_ins.push_back(ins_exp_t'{32'h2222_2000, 64'h3000, -1});
        fb.pc_valid = 1'b1;
        ack(0);
        feed(64'h3000, 1'b0, -1, 8);
        step();
        fb.pc_valid = 1'b0;

        // Reset after three beats of a fill for 0x4000.
        fb.pc       = 64'h4000;
        fb.pc_valid = 1'b1;
        exp_req.push_back(64'h4000);
        step();
        ack(0);
        feed(64'h4000, 1'b0, -1, 3);
        fb.bus_respcyc = 1'b1;
        fb.pc_valid    = 1'b0;
        reset          = 1'b1;
        #1;
        check64("rst_fill_respack", {63'h0, fb.bus_respack}, 64'h0);
        step();
        reset = 1'b0;
        #1;
        check64("post_rst_respack", {63'h0, fb.bus_respack}, 64'h0);
        check64("post_rst_reqcyc", {63'h0, fb.bus_reqcyc}, 64'h0);
        check64("post_rst_ins_valid", {63'h0, fb.ins_valid}, 64'h0);
        fb.bus_respcyc = 1'b0;
        step();

        // 0x3000 was valid before reset; it must miss now.
        exp_ins.push_back(ins_exp_t'{32'h1111_2000, 64'h3004, -1});
        fill(64'h3004, 1, 1'b0, -1);

        repeat (3) step();
        check64("ins_queue_drained", 64'(exp_ins.size()), 64'h0);
        check64("req_queue_drained", 64'(exp_req.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_line_buffer.md
# fetch_line_buffer

Single-line instruction buffer between the fetch stage and the instruction port of the bus arbiter. It holds one 64-byte aligned line of instructions. On a hit it returns the 32-bit instruction at `pc`. On a miss it issues one read request on the instruction bus, collects an 8-beat burst, and then serves the instruction. This removes one bus round trip per instruction for straight-line code.

## Interface
- `BUS_DATA_WIDTH`, 64, bus data and address width
- `BUS_TAG_WIDTH`, 13, bus tag width
- `READ_TAG`, 13'h1100, tag driven on every line-read request
- `LINE_BEATS`, 8, beats per line (line = LINE_BEATS*8 bytes = 64 B)

Ports:
- `clk` in 1, clock
- `reset` in 1, reset, synchronous, active-high
- `pc` in 64, fetch address (bits [1:0] ignored)
- `pc_valid` in 1, fetch request this cycle
- `flush` in 1, invalidate buffered line
- `ins_valid` out 1, `ins`/`ins_addr` valid this cycle
- `ins` out 32, instruction word
- `ins_addr` out 64, address of `ins`
- `bus_reqcyc` out 1, request valid
- `bus_req` out 64, request address (line-aligned)
- `bus_reqtag` out 13, request tag
- `bus_reqack` in 1, request accepted
- `bus_respcyc` in 1, response beat valid
- `bus_resp` in 64, response data
- `bus_resptag` in 13, response tag (not checked)
- `bus_respack` out 1, response beat accepted

## Operation
- State: `line_tag[63:6]`, `line_valid`, 8×64 data array, `beat_cnt[2:0]`, `discard`, FSM {IDLE, REQ, FILL}.
- Hit: IDLE & pc_valid & line_valid & line_tag==pc[63:6] & !flush.
- Word select:
  - beat = pc[5:3]
  - pc[2]=0 → bits [31:0]
  - pc[2]=1 → bits [63:32]
- IDLE behaviour:
  - On a hit, register `ins`, `ins_addr`={pc[63:2],2'b00} and `ins_valid`=1.
  - On a miss with pc_valid, latch `req_addr`={pc[63:6],6'b0}, go to REQ. `ins_valid`=0.
  - With pc_valid=0, `ins_valid`=0.
- REQ:
  - Drive `bus_reqcyc`=1, `bus_req`=req_addr, `bus_reqtag`=READ_TAG.
  - Hold all three stable until `bus_reqack`.
  - On the reqack cycle, go to FILL with beat_cnt=0 and line_valid=0.
- FILL:
  - `bus_respack` = `bus_respcyc` (combinational).
  - Each accepted beat writes data[beat_cnt] and increments beat_cnt.
  - Beats arrive in ascending address order from req_addr.
  - On the beat with beat_cnt==7, go to IDLE, set line_tag=req_addr[63:6] and line_valid=!discard, then clear discard.
- `bus_reqcyc`=0 outside REQ. `bus_respack`=0 outside FILL.
- `ins_valid`=0 in REQ and FILL.
- A change of `pc` during REQ/FILL does not abort the fill. Lookup resumes in IDLE with the current pc, and a new miss starts a new request.
- `flush`:
  - In IDLE, clears line_valid; a flush cycle is never a hit.
  - In REQ/FILL, sets discard. The fill completes on the bus but the line is left invalid.
- Outputs `ins`/`ins_addr` hold their last value when `ins_valid`=0.

## Timing
- Reset values:
  - FSM=IDLE, line_valid=0, beat_cnt=0, discard=0, line_tag=0
  - ins_valid=0, ins=0, ins_addr=0
  - bus_reqcyc=0, bus_req=0, bus_reqtag=0
  - bus_respack=0
- Hit latency: pc presented in cycle N → ins_valid in N+1.
- Miss latency, with pc presented in cycle N:
  - REQ in N+1.
  - reqack in cycle R≥N+1 → FILL from R+1.
  - 8th beat accepted in cycle F → IDLE in F+1, hit lookup in F+1, ins_valid in F+2.
  - Minimum (ack at N+1, gapless beats N+2..N+9): ins_valid at N+11.
- Gaps in respcyc stall beat_cnt; there is no timeout.
- Reset mid-REQ/FILL takes priority in the same edge:
  - Everything returns to reset values and the partial line is discarded.
  - Beats still in flight are not acked.
- Simultaneous flush and last beat: the line is not validated.
- Simultaneous reqack and flush: go to FILL with discard=1.
- beat_cnt wraps 7→0 only on exit to IDLE.

## Test plan
- Reset: assert reset 2 cycles with respcyc=1 → all outputs 0, no request issued.
- Cold miss:
  - pc=0x1004, pc_valid=1, reqack same cycle as reqcyc.
  - Expect bus_req=0x1000 and tag 0x1100.
  - Feed beats 0x11110000_22220000 + i, i=0..7.
  - Expect ins=0x11110000 and ins_addr=0x1004, 11 cycles after the pc cycle.
- Hits:
  - Then pc=0x1038 → next cycle ins=0x22220007.
  - Then pc=0x1000 → ins=0x22220000, with no bus activity.
- Delayed ack and gaps:
  - Miss at pc=0x2000, reqack 3 cycles late, respcyc toggling 1/0.
  - Expect req held stable, respack tracking respcyc, exactly 8 beats accepted, correct data.
- Flush mid-fill:
  - Assert flush on beat 4 of a fill for 0x3000, keep pc=0x3000.
  - Expect a second request to 0x3000 after the fill completes.
- Reset mid-fill:
  - Assert reset after beat 3.
  - Expect FSM in IDLE and respack=0; then pc=0x1000 misses (line invalid).
